// File: rtl/uart_byte_fifo_if.sv
// uart_byte_fifo_if
//   Handshake bundle between a uart_byte_fifo and the logic that fills or
//   drains it (UART RX/TX side or the memory command controller).
//
//   master modport : the producer/consumer side (drives wr_en, din, rd_en)
//   slave modport  : the FIFO itself (drives full, dout, empty, count)
//
//   Signals:
//     wr_en   enqueue request
//     din     write data, WIDTH bits
//     full    no free entry
//     rd_en   dequeue request
//     dout    registered read data, WIDTH bits
//     empty   no stored entry
//     count   occupancy 0..DEPTH, PTR_W+1 bits
//   With UART_BYTE_FIFO_ERR_FLAGS_EN defined, two extra signals are carried:
//     overflow   sticky: a write was attempted while full
//     underflow  sticky: a read was attempted while empty
interface uart_byte_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             full;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic [PTR_W:0]   count;
`ifdef UART_BYTE_FIFO_ERR_FLAGS_EN
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, din, rd_en,
        input  full, dout, empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en,
        output full, dout, empty, count, overflow, underflow
    );
`else
    modport master (
        output wr_en, din, rd_en,
        input  full, dout, empty, count
    );

    modport slave (
        input  wr_en, din, rd_en,
        output full, dout, empty, count
    );
`endif
endinterface

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo
//   Single-clock byte FIFO used as the UART RX and TX queues around the
//   memory command controller. Read data is registered (one cycle after an
//   accepted rd_en); full/empty/count are decoded from a registered
//   occupancy counter, so there is no combinational path from the requests
//   to the flags.
//
//   Ports:
//     clk   clock, rising edge
//     rst   synchronous active-high reset (clears pointers, count, dout)
//     bus   uart_byte_fifo_if.slave: wr_en/din/full, rd_en/dout/empty, count
//
//   Optional: define UART_BYTE_FIFO_ERR_FLAGS_EN to add sticky overflow and
//   underflow flags on the interface. They do not affect the data path.
module uart_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_byte_fifo_if.slave       bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W:0]   cnt;
    logic [WIDTH-1:0] dout_q;
    logic             full_w;
    logic             empty_w;
    logic             we_ok;
    logic             re_ok;

    assign full_w  = (cnt == CNT_FULL);
    assign empty_w = (cnt == '0);

    // Both accepts look at the pre-edge flags: a write into a full FIFO is
    // dropped even when a read frees a slot on the same edge, and a read of
    // an empty FIFO never falls through to the word being written.
    assign we_ok = bus.wr_en && !full_w;
    assign re_ok = bus.rd_en && !empty_w;

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && we_ok) begin
            mem[wptr] <= bus.din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr   <= '0;
            rptr   <= '0;
            cnt    <= '0;
            dout_q <= '0;
        end else begin
            if (we_ok) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (re_ok) begin
                rptr   <= rptr + PTR_W'(1);
                dout_q <= mem[rptr];
            end
            case ({we_ok, re_ok})
                2'b10:   cnt <= cnt + (PTR_W+1)'(1);
                2'b01:   cnt <= cnt - (PTR_W+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign bus.full  = full_w;
    assign bus.empty = empty_w;
    assign bus.count = cnt;
    assign bus.dout  = dout_q;

`ifdef UART_BYTE_FIFO_ERR_FLAGS_EN
    logic ovf_q;
    logic unf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (bus.wr_en && full_w) begin
                ovf_q <= 1'b1;
            end
            if (bus.rd_en && empty_w) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`endif
endmodule

// File: tb/tb_uart_byte_fifo.sv
module tb_uart_byte_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_byte_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    uart_byte_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a queue of stored bytes and the last byte read out.
    logic [7:0] q[$];
    logic [7:0] m_dout = 8'h00;
    logic       m_ovf  = 1'b0;
    logic       m_unf  = 1'b0;

    // Drive one clock cycle of stimulus and advance the model over the edge.
    task automatic cycle(input logic r, input logic we, input logic re, input logic [7:0] d);
        bit was_full;
        bit was_empty;
        rst       = r;
        bus.wr_en = we;
        bus.rd_en = re;
        bus.din   = d;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_dout = 8'h00;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            if (we && was_full) m_ovf = 1'b1;
            if (re && was_empty) m_unf = 1'b1;
            if (re && !was_empty) m_dout = q.pop_front();
            if (we && !was_full) q.push_back(d);
        end
        #1;
        rst       = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    function automatic logic [15:0] model_state();
        return {6'(q.size()), q.size() == 0, q.size() == DEPTH, m_dout};
    endfunction

    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if ({bus.count, bus.empty, bus.full, bus.dout} !== {6'd0, 1'b1, 1'b0, 8'h00})
            $display("FAIL reset_state: got count=%0d empty=%b full=%b dout=%h, want 0/1/0/00",
                     bus.count, bus.empty, bus.full, bus.dout);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        n_checks++;
        if ({bus.count, bus.empty, bus.dout} !== {6'd0, 1'b1, 8'h00})
            $display("FAIL read_while_empty: got count=%0d empty=%b dout=%h, want 0/1/00",
                     bus.count, bus.empty, bus.dout);
        else n_pass++;
`ifdef UART_BYTE_FIFO_ERR_FLAGS_EN
        n_checks++;
        if ({bus.underflow, bus.overflow} !== 2'b10)
            $display("FAIL underflow_flag: got unf=%b ovf=%b, want 1/0", bus.underflow, bus.overflow);
        else n_pass++;
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
`endif
    endtask

    task automatic test_single();
        cycle(1'b0, 1'b1, 1'b0, 8'h30);
        n_checks++;
        if ({bus.count, bus.empty} !== {6'd1, 1'b0})
            $display("FAIL single_count1: got count=%0d empty=%b, want 1/0", bus.count, bus.empty);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        n_checks++;
        if ({bus.count, bus.empty, bus.dout} !== {6'd0, 1'b1, 8'h30})
            $display("FAIL single_read: got count=%0d empty=%b dout=%h, want 0/1/30",
                     bus.count, bus.empty, bus.dout);
        else n_pass++;
    endtask

    task automatic test_fill();
        int bad;
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 8'(i));
        n_checks++;
        if ({bus.count, bus.full, bus.empty} !== {6'd32, 1'b1, 1'b0})
            $display("FAIL fill_full: got count=%0d full=%b empty=%b, want 32/1/0",
                     bus.count, bus.full, bus.empty);
        else n_pass++;
        cycle(1'b0, 1'b1, 1'b0, 8'hAA);
        n_checks++;
        if ({bus.count, bus.full} !== {6'd32, 1'b1})
            $display("FAIL fill_drop: got count=%0d full=%b, want 32/1", bus.count, bus.full);
        else n_pass++;
`ifdef UART_BYTE_FIFO_ERR_FLAGS_EN
        n_checks++;
        if (bus.overflow !== 1'b1)
            $display("FAIL overflow_flag: got %b, want 1", bus.overflow);
        else n_pass++;
`endif
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 8'h00);
            if (bus.dout !== 8'(i)) begin
                if (bad == 0)
                    $display("FAIL drain_order: word %0d got dout=%h, want %h", i, bus.dout, 8'(i));
                bad++;
            end
        end
        n_checks++;
        if (bad != 0 || bus.empty !== 1'b1)
            $display("FAIL drain_all: got %0d wrong words empty=%b, want 0 wrong empty=1", bad, bus.empty);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int written, read_n, max_cnt, bad, budget;
        logic we, re;
        written = 0; read_n = 0; max_cnt = 0; bad = 0; budget = 2000;
        while ((written < 48 || read_n < 48) && budget > 0) begin
            we = (written < 48) && (q.size() < 5) && ($urandom_range(0, 1) == 1);
            re = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            cycle(1'b0, we, re, 8'($urandom));
            if (we) written++;
            if (re) read_n++;
            if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
            if ({bus.count, bus.empty, bus.full, bus.dout} !== model_state()) bad++;
            budget--;
        end
        n_checks++;
        if (budget == 0)
            $display("FAIL wrap_timeout: got %0d/%0d words through, want 48/48", written, read_n);
        else if (bad != 0 || max_cnt > 5)
            $display("FAIL wrap_stream: got %0d bad cycles max_count=%0d, want 0 and <=5", bad, max_cnt);
        else n_pass++;
    endtask

    task automatic test_simul();
        logic [15:0] exp;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 4; i++) begin
            exp = q[0];
            cycle(1'b0, 1'b1, 1'b1, 8'($urandom));
            n_checks++;
            if ({bus.count, bus.dout} !== {6'd3, exp[7:0]})
                $display("FAIL simul_mid%0d: got count=%0d dout=%h, want 3/%h", i, bus.count, bus.dout, exp[7:0]);
            else n_pass++;
        end
        while (q.size() < DEPTH) cycle(1'b0, 1'b1, 1'b0, 8'($urandom));
        exp = q[0];
        cycle(1'b0, 1'b1, 1'b1, 8'h5A);
        n_checks++;
        if ({bus.count, bus.full, bus.dout} !== {6'd31, 1'b0, exp[7:0]})
            $display("FAIL simul_full: got count=%0d full=%b dout=%h, want 31/0/%h",
                     bus.count, bus.full, bus.dout, exp[7:0]);
        else n_pass++;
        while (q.size() > 0) cycle(1'b0, 1'b0, 1'b1, 8'h00);
        exp = m_dout;
        cycle(1'b0, 1'b1, 1'b1, 8'hC3);
        n_checks++;
        if ({bus.count, bus.empty, bus.dout} !== {6'd1, 1'b0, exp[7:0]})
            $display("FAIL simul_empty: got count=%0d empty=%b dout=%h, want 1/0/%h",
                     bus.count, bus.empty, bus.dout, exp[7:0]);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        n_checks++;
        if ({bus.count, bus.dout} !== {6'd0, 8'hC3})
            $display("FAIL simul_empty_read: got count=%0d dout=%h, want 0/c3", bus.count, bus.dout);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 8'($urandom));
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b1, 1'b0, 8'h77);
        n_checks++;
        if ({bus.count, bus.empty, bus.full, bus.dout} !== {6'd0, 1'b1, 1'b0, 8'h00})
            $display("FAIL reset_mid: got count=%0d empty=%b full=%b dout=%h, want 0/1/0/00",
                     bus.count, bus.empty, bus.full, bus.dout);
        else n_pass++;
        cycle(1'b0, 1'b1, 1'b0, 8'h31);
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        n_checks++;
        if ({bus.count, bus.dout} !== {6'd0, 8'h31})
            $display("FAIL reset_mid_after: got count=%0d dout=%h, want 0/31", bus.count, bus.dout);
        else n_pass++;
    endtask

    task automatic test_random();
        int bad;
        logic [15:0] exp;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            // Bias toward filling in the first half and draining in the second
            // so both flags get exercised.
            cycle(1'b0,
                  $urandom_range(0, 9) < (i < 200 ? 7 : 3),
                  $urandom_range(0, 9) < (i < 200 ? 3 : 7),
                  8'($urandom));
            exp = model_state();
            if ({bus.count, bus.empty, bus.full, bus.dout} !== exp) begin
                if (bad == 0)
                    $display("FAIL random_cycle%0d: got {count,empty,full,dout}=%h, want %h",
                             i, {bus.count, bus.empty, bus.full, bus.dout}, exp);
                bad++;
            end
        end
        n_checks++;
        if (bad != 0)
            $display("FAIL random_total: got %0d bad cycles, want 0", bad);
        else n_pass++;
`ifdef UART_BYTE_FIFO_ERR_FLAGS_EN
        n_checks++;
        if ({bus.overflow, bus.underflow} !== {m_ovf, m_unf})
            $display("FAIL random_flags: got ovf=%b unf=%b, want %b/%b",
                     bus.overflow, bus.underflow, m_ovf, m_unf);
        else n_pass++;
`endif
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.din   = 8'h00;
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_simul();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
